// File: rtl/regbank_arbiter.sv
// Round-robin arbiter sharing one single-port 8-entry register bank between NOF_REQ requesters.
// Writes issue back-to-back; a read holds the bank for three cycles until data returns to its owner.
module regbank_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NOF_REQ = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NOF_REQ-1:0]       req_i,
  input  logic [NOF_REQ-1:0]       we_i,
  input  logic [3*NOF_REQ-1:0]     addr_i,
  input  logic [WIDTH*NOF_REQ-1:0] wdata_i,
  output logic [NOF_REQ-1:0]       gnt_o,
  output logic [NOF_REQ-1:0]       rvalid_o,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     busy_o,
  output logic                     bank_we_o,
  output logic                     bank_re_o,
  output logic [2:0]               bank_addr_o,
  output logic [WIDTH-1:0]         bank_wdata_o,
  input  logic [WIDTH-1:0]         bank_rdata_i
);

  if (WIDTH < 1) begin : g_bad_width
    $error("regbank_arbiter: WIDTH must be at least 1");
  end
  if (NOF_REQ < 2 || NOF_REQ > 8) begin : g_bad_nof_req
    $error("regbank_arbiter: NOF_REQ must be in 2..8");
  end

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT} state_t;

  state_t state, state_nxt;

  logic [2:0] ptr, win, owner;
  logic [3:0] cand;
  logic       any, accept, sel_we;
  logic [2:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic [7:0] req_pad;

  logic [NOF_REQ-1:0][2:0]       addr_v;
  logic [NOF_REQ-1:0][WIDTH-1:0] wdata_v;

  assign addr_v  = addr_i;
  assign wdata_v = wdata_i;
  assign req_pad = 8'(req_i);

  // Scan from ptr+1 upward with wrap; the first requester found wins.
  always_comb begin
    any  = 1'b0;
    win  = ptr;
    cand = '0;
    for (int i = 1; i <= NOF_REQ; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'(NOF_REQ)) cand = cand - 4'(NOF_REQ);
      if (!any && req_pad[cand[2:0]]) begin
        any = 1'b1;
        win = cand[2:0];
      end
    end
  end

  assign accept = (state == IDLE) && any;
  assign busy_o = (state != IDLE);

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    gnt_o     = '0;
    for (int k = 0; k < NOF_REQ; k++) begin
      if (win == 3'(k)) begin
        sel_we    = we_i[k];
        sel_addr  = addr_v[k];
        sel_wdata = wdata_v[k];
        gnt_o[k]  = accept;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && !sel_we) state_nxt = RD_ISSUE;
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Address/write data only load on a grant, so they hold between strobes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr          <= 3'(NOF_REQ - 1);
      owner        <= '0;
      bank_we_o    <= 1'b0;
      bank_re_o    <= 1'b0;
      bank_addr_o  <= '0;
      bank_wdata_o <= '0;
      rvalid_o     <= '0;
      rdata_o      <= '0;
    end else begin
      bank_we_o <= accept && sel_we;
      bank_re_o <= accept && !sel_we;
      if (accept) begin
        ptr         <= win;
        bank_addr_o <= sel_addr;
        if (sel_we) bank_wdata_o <= sel_wdata;
        else        owner        <= win;
      end
      rvalid_o <= '0;
      if (state == RD_WAIT) begin
        for (int k = 0; k < NOF_REQ; k++) rvalid_o[k] <= (owner == 3'(k));
        rdata_o <= bank_rdata_i;
      end
    end
  end

endmodule
